// File: rtl/spu32_cpu_fetch_pkg.sv
// -----------------------------------------------------------------------------
// spu32_cpu_fetch_pkg
// Shared definitions for the SPU32 instruction fetch unit: instruction width,
// fetch FSM state encoding and a word-alignment helper.
// Optional feature macro: SPU32_FETCH_MISALIGN_TRAP_EN (adds the TRAP state).
// -----------------------------------------------------------------------------
package spu32_cpu_fetch_pkg;

  localparam int INSTR_W = 32;

`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,  // reset / pre-fetch, no bus request
    ST_REQ     = 3'd1,  // read outstanding, waiting for ack
    ST_HOLD    = 3'd2,  // instruction valid, waiting for decoder ready
    ST_DISCARD = 3'd3,  // outstanding read will be dropped
    ST_TRAP    = 3'd4   // misaligned redirect target, idle
  } fetch_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DISCARD = 3'd3
  } fetch_state_e;
`endif

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return {a[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/spu32_cpu_fetchbuf.sv
// -----------------------------------------------------------------------------
// spu32_cpu_fetchbuf
// Single-entry holding register for a fetched instruction and its PC.
// Ports:
//   I_clk, I_reset_n        clock, asynchronous active-low reset
//   I_load_i                capture I_instr_i / I_pc_i and set valid
//   I_clear_i               drop valid (instr/pc contents are kept)
//   I_instr_i, I_pc_i       data to capture
//   O_instr_o, O_pc_o       held instruction / PC
//   O_valid_o               holding register contains a live instruction
// -----------------------------------------------------------------------------
module spu32_cpu_fetchbuf
  import spu32_cpu_fetch_pkg::*;
(
  input  logic               I_clk,
  input  logic               I_reset_n,
  input  logic               I_load_i,
  input  logic               I_clear_i,
  input  logic [INSTR_W-1:0] I_instr_i,
  input  logic [31:0]        I_pc_i,
  output logic [INSTR_W-1:0] O_instr_o,
  output logic [31:0]        O_pc_o,
  output logic               O_valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;
  logic               valid_q;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (I_load_i) begin
      instr_q <= I_instr_i;
      pc_q    <= I_pc_i;
      valid_q <= 1'b1;
    end else if (I_clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign O_instr_o = instr_q;
  assign O_pc_o    = pc_q;
  assign O_valid_o = valid_q;

endmodule

// File: rtl/spu32_cpu_fetch.sv
// -----------------------------------------------------------------------------
// spu32_cpu_fetch
// Instruction fetch unit: issues word reads on a simple stb/ack bus, holds one
// fetched instruction for the decoder, and restarts on redirect (branch/jump).
// A redirect raised while a read is outstanding lets that read finish on the
// bus (stb/addr stay stable) and drops its data.
// Ports:
//   I_clk, I_reset_n                  clock, asynchronous active-low reset
//   I_redirect, I_redirect_addr       restart fetch at a new address
//   I_instr_ready                     decoder accepts O_instr
//   O_instr, O_instr_valid, O_pc      fetched instruction to decoder
//   O_bus_stb, O_bus_addr             bus read request (word address)
//   I_bus_ack, I_bus_data             bus read completion and data
//   O_misaligned                      redirect target not word aligned
// Macro SPU32_FETCH_MISALIGN_TRAP_EN: misaligned redirect targets enter a TRAP
// state instead of being silently word-aligned.
// -----------------------------------------------------------------------------
module spu32_cpu_fetch
  import spu32_cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic               I_clk,
  input  logic               I_reset_n,
  input  logic               I_redirect,
  input  logic [31:0]        I_redirect_addr,
  input  logic               I_instr_ready,
  output logic [INSTR_W-1:0] O_instr,
  output logic               O_instr_valid,
  output logic [31:0]        O_pc,
  output logic               O_bus_stb,
  output logic [31:0]        O_bus_addr,
  input  logic               I_bus_ack,
  input  logic [INSTR_W-1:0] I_bus_data,
  output logic               O_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;   // current / next fetch address
  logic [31:0]  tgt_q, tgt_d;     // redirect target latched while discarding
  logic         buf_load, buf_clear;

  // Pending "start fetching at launch_addr" request from the FSM.
  logic         launch;
  logic [31:0]  launch_raw;

`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
`endif

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= RESET_VECTOR;
      tgt_q   <= '0;
`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tgt_d      = tgt_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    launch     = 1'b0;
    launch_raw = I_redirect_addr;
`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
    mis_d      = mis_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A late ack from a read killed by reset lands here and is ignored.
        if (I_redirect) launch = 1'b1;
        else            state_d = ST_REQ;
      end
      ST_REQ: begin
        if (I_redirect) begin
          if (I_bus_ack) begin
            launch = 1'b1;
          end else begin
            tgt_d   = I_redirect_addr;
            state_d = ST_DISCARD;
          end
        end else if (I_bus_ack) begin
          buf_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (I_redirect) begin
          buf_clear = 1'b1;
          launch    = 1'b1;
        end else if (I_instr_ready) begin
          buf_clear = 1'b1;
          addr_d    = O_pc + 32'd4;
          state_d   = ST_REQ;
        end
      end
      ST_DISCARD: begin
        // Redirect and ack together: old read is done, go straight to the
        // newest target. Redirect alone only replaces the latched target.
        if (I_redirect) begin
          if (I_bus_ack) launch = 1'b1;
          else           tgt_d  = I_redirect_addr;
        end else if (I_bus_ack) begin
          launch     = 1'b1;
          launch_raw = tgt_q;
        end
      end
`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
      ST_TRAP: begin
        if (I_redirect) launch = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
      if (launch_raw[1:0] != 2'b00) begin
        state_d = ST_TRAP;
        mis_d   = 1'b1;
      end else
`endif
      begin
        state_d = ST_REQ;
        addr_d  = word_align(launch_raw);
`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
      end
    end
  end

  spu32_cpu_fetchbuf u_fetchbuf (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .I_load_i  (buf_load),
    .I_clear_i (buf_clear),
    .I_instr_i (I_bus_data),
    .I_pc_i    (addr_q),
    .O_instr_o (O_instr),
    .O_pc_o    (O_pc),
    .O_valid_o (O_instr_valid)
  );

  assign O_bus_stb  = (state_q == ST_REQ) || (state_q == ST_DISCARD);
  assign O_bus_addr = addr_q;

`ifdef SPU32_FETCH_MISALIGN_TRAP_EN
  assign O_misaligned = mis_q;
`else
  assign O_misaligned = 1'b0;
`endif

endmodule
